// File: rtl/bsg_regs_pkg.sv
// Register map constants and access-type lookup shared by the BSG register bank.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package bsg_regs_pkg;

  // Register indices relative to BASE_ADDR.
  localparam int unsigned IDX_CONTROL = 0;
  localparam int unsigned IDX_STATUS  = 1;
  localparam int unsigned IDX_DATA0   = 2;

  // CONTROL bit positions.
  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_W1C,
    ACC_SHADOW
  } reg_access_t;

  // Access type of a register index; anything at or above IDX_DATA0 is a
  // double-buffered data register.
  function automatic reg_access_t reg_access(input int unsigned idx);
    if (idx == IDX_CONTROL) return ACC_RW;
    if (idx == IDX_STATUS)  return ACC_W1C;
    return ACC_SHADOW;
  endfunction

endpackage

// File: rtl/bsg_shadow_reg.sv
// Double-buffered data register: software writes the shadow, commit copies it to active.
// Latency: shadow and active update on the edge that samples we/commit.
// Backpressure: none; every write/commit completes in one cycle.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   we, wdata     shadow write enable and data
//   commit        copy shadow into active on this edge
//   shadow        software-visible value
//   active        core-facing committed value
module bsg_shadow_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] shadow,
  output logic [DATA_WIDTH-1:0] active
);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (we) begin
        shadow <= wdata;
      end
      // A commit captures the shadow as it was before this edge.
      if (commit) begin
        active <= shadow;
      end
    end
  end

endmodule

// File: rtl/bsg_reg_bank.sv
// Addressed register bank: CONTROL (RW + commit), STATUS (W1C + hw set), double-buffered DATA.
// Latency: reads return data_out/rd_valid one cycle after the request; writes take effect on the sampling edge.
// Backpressure: none; every request completes in fixed time, misses pulse addr_err.
//
// Ports:
//   SYS_CLK, rst              clock and synchronous active-high reset
//   read_flag, write_flag     access strobes, amba_addr/data_in qualify them
//   data_out, rd_valid        registered read data and its one-cycle strobe
//   addr_err                  one-cycle strobe for an access outside the map
//   hw_status_set             per-bit set pulses into STATUS
//   data_active               committed DATA values, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   commit_pulse, irq         commit strobe and level interrupt
module bsg_reg_bank
  import bsg_regs_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h10
) (
  input  logic                                 SYS_CLK,
  input  logic                                 rst,
  input  logic                                 read_flag,
  input  logic                                 write_flag,
  input  logic [ADDR_WIDTH-1:0]                amba_addr,
  input  logic [DATA_WIDTH-1:0]                data_in,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic                                 rd_valid,
  output logic                                 addr_err,
  input  logic [DATA_WIDTH-1:0]                hw_status_set,
  output logic [(NUM_REGS-2)*DATA_WIDTH-1:0]   data_active,
  output logic                                 commit_pulse,
  output logic                                 irq
);

  localparam int NUM_DATA = NUM_REGS - 2;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  hit;
  reg_access_t           acc;
  logic                  wr_hit;
  logic                  wr_ctrl;
  logic                  commit;
  logic [DATA_WIDTH-1:0] ctrl_d;
  logic [DATA_WIDTH-1:0] w1c_mask;
  logic [DATA_WIDTH-1:0] rd_val;

  logic [DATA_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] status_q;
  logic [NUM_DATA-1:0]   shadow_we;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_DATA];
  logic [DATA_WIDTH-1:0] active_q [NUM_DATA];

  // The lower-bound test guards against the subtraction wrapping for
  // addresses below BASE_ADDR.
  assign idx = amba_addr - BASE_ADDR;
  assign hit = (amba_addr >= BASE_ADDR) && (idx < ADDR_WIDTH'(NUM_REGS));
  // Only meaningful under hit, where idx < NUM_REGS, so narrowing is safe.
  assign acc = reg_access(32'(idx));

  assign wr_hit  = write_flag && hit;
  assign wr_ctrl = wr_hit && (acc == ACC_RW);
  assign commit  = wr_ctrl && data_in[CTRL_COMMIT_BIT];

  // COMMIT is a trigger, never stored, so CONTROL always reads it as 0.
  always_comb begin
    ctrl_d                  = data_in;
    ctrl_d[CTRL_COMMIT_BIT] = 1'b0;
  end

  assign w1c_mask = (wr_hit && (acc == ACC_W1C)) ? data_in : '0;

  // Read mux works on pre-write state, giving read-before-write semantics
  // when a read and write hit the same register together.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (acc)
        ACC_RW:  rd_val = ctrl_q;
        ACC_W1C: rd_val = status_q;
        ACC_SHADOW: begin
          for (int k = 0; k < NUM_DATA; k++) begin
            if (idx == ADDR_WIDTH'(IDX_DATA0 + k)) begin
              rd_val = shadow_q[k];
            end
          end
        end
        default: rd_val = '0;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_DATA; k++) begin : g_data
    assign shadow_we[k] = wr_hit && (acc == ACC_SHADOW) &&
                          (idx == ADDR_WIDTH'(IDX_DATA0 + k));

    bsg_shadow_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow (
      .clk    (SYS_CLK),
      .rst    (rst),
      .we     (shadow_we[k]),
      .commit (commit),
      .wdata  (data_in),
      .shadow (shadow_q[k]),
      .active (active_q[k])
    );

    assign data_active[k*DATA_WIDTH +: DATA_WIDTH] = active_q[k];
  end

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      ctrl_q       <= '0;
      status_q     <= '0;
      data_out     <= '0;
      rd_valid     <= 1'b0;
      addr_err     <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= ctrl_d;
      end
      // Set has priority over a same-cycle clear.
      status_q     <= (status_q & ~w1c_mask) | hw_status_set;
      rd_valid     <= read_flag;
      if (read_flag) begin
        data_out <= rd_val;
      end
      addr_err     <= (read_flag || write_flag) && !hit;
      commit_pulse <= commit;
    end
  end

  // Built only from flops, so no input-to-irq combinational path.
  assign irq = ctrl_q[CTRL_IRQ_EN_BIT] && (|status_q);

endmodule
